// File: rtl/splitting_pkg.sv
// Shared definitions for the 4KB splitter read-data path:
// merge state encoding, default widths and AXI RRESP codes.
package splitting_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ID_WIDTH   = 5;
    localparam int DEF_RESP_WIDTH = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    // PART_FIRST  | waiting for the RLAST of the first (or only) sub-burst
    // PART_SECOND | first half of a split burst done, waiting for the final RLAST
    typedef enum logic {
        PART_FIRST  = 1'b0,
        PART_SECOND = 1'b1
    } merge_state_e;

endpackage

// File: rtl/split_flag_fifo.sv
// Small synchronous FIFO holding one crossing flag per outstanding AR.
// A push while full is dropped even if a pop happens in the same cycle.
module split_flag_fifo #(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Register FIFO state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/splitting_4kb_rdata_merger.sv
// Re-joins the two downstream R sub-bursts of a 4KB-crossing read into one
// upstream burst. The RLAST closing the first half is suppressed; the queue
// entry for an AR retires only on the RLAST that completes the merge.
module splitting_4kb_rdata_merger
    import splitting_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int RESP_WIDTH = DEF_RESP_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  ACLK_i,
    input  logic                  ARESET_i,
    input  logic                  ar_push_i,
    input  logic                  crossing_flag_i,
    output logic                  ar_full_o,
    input  logic [ID_WIDTH-1:0]   s_RID_i,
    input  logic [DATA_WIDTH-1:0] s_RDATA_i,
    input  logic [RESP_WIDTH-1:0] s_RRESP_i,
    input  logic                  s_RLAST_i,
    input  logic                  s_RVALID_i,
    output logic                  s_RREADY_o,
    output logic [ID_WIDTH-1:0]   m_RID_o,
    output logic [DATA_WIDTH-1:0] m_RDATA_o,
    output logic [RESP_WIDTH-1:0] m_RRESP_o,
    output logic                  m_RLAST_o,
    output logic                  m_RVALID_o,
    input  logic                  m_RREADY_i
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [0:0]       flag_head;
    logic [CNT_W-1:0] flag_count;
    logic             flag_full;
    logic             flag_empty;
    logic             flag_push;
    logic             flag_pop;
    logic             beat_acc;

    merge_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0]   m_rid_q, m_rid_d;
    logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;
    logic [RESP_WIDTH-1:0] m_rresp_q, m_rresp_d;
    logic                  m_rlast_q, m_rlast_d;
    logic                  m_rvalid_q, m_rvalid_d;

    assign flag_push = ar_push_i & ~flag_full;

    split_flag_fifo #(
        .WIDTH (1),
        .DEPTH (FIFO_DEPTH)
    ) u_flag_fifo (
        .clk     (ACLK_i),
        .rst     (ARESET_i),
        .push_i  (flag_push),
        .wdata_i (crossing_flag_i),
        .pop_i   (flag_pop),
        .head_o  (flag_head),
        .count_o (flag_count),
        .full_o  (flag_full),
        .empty_o (flag_empty)
    );

    assign ar_full_o  = (flag_count == CNT_W'(FIFO_DEPTH));
    assign m_RID_o    = m_rid_q;
    assign m_RDATA_o  = m_rdata_q;
    assign m_RRESP_o  = m_rresp_q;
    assign m_RLAST_o  = m_rlast_q;
    assign m_RVALID_o = m_rvalid_q;

    // Accept a beat when a flag is queued and the output slot is free or draining;
    // decide RLAST suppression and queue retirement from the head flag and merge state.
    always_comb begin
        s_RREADY_o = ~flag_empty & (~m_rvalid_q | m_RREADY_i);
        beat_acc   = s_RVALID_i & s_RREADY_o;
        state_d    = state_q;
        m_rid_d    = m_rid_q;
        m_rdata_d  = m_rdata_q;
        m_rresp_d  = m_rresp_q;
        m_rlast_d  = m_rlast_q;
        m_rvalid_d = m_rvalid_q;
        flag_pop   = 1'b0;
        if (beat_acc) begin
            m_rid_d    = s_RID_i;
            m_rdata_d  = s_RDATA_i;
            m_rresp_d  = s_RRESP_i;
            m_rvalid_d = 1'b1;
            m_rlast_d  = 1'b0;
            if (s_RLAST_i) begin
                if ((state_q == PART_FIRST) && flag_head[0]) begin
                    state_d = PART_SECOND;
                end else begin
                    m_rlast_d = 1'b1;
                    flag_pop  = 1'b1;
                    state_d   = PART_FIRST;
                end
            end
        end else if (m_rvalid_q & m_RREADY_i) begin
            m_rvalid_d = 1'b0;
        end
    end

    // Merge state and registered output stage.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            state_q    <= PART_FIRST;
            m_rid_q    <= '0;
            m_rdata_q  <= '0;
            m_rresp_q  <= RRESP_OKAY;
            m_rlast_q  <= 1'b0;
            m_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_rid_q    <= m_rid_d;
            m_rdata_q  <= m_rdata_d;
            m_rresp_q  <= m_rresp_d;
            m_rlast_q  <= m_rlast_d;
            m_rvalid_q <= m_rvalid_d;
        end
    end

endmodule

// File: tb/tb_splitting_4kb_rdata_merger.sv
// Bench for the R-channel merger: directed scenarios with literal expectations,
// then randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_splitting_4kb_rdata_merger;

    localparam int DW    = 32;
    localparam int IW    = 5;
    localparam int RW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          ARESET_i;
    logic          ar_push_i;
    logic          crossing_flag_i;
    logic          ar_full_o;
    logic [IW-1:0] s_RID_i;
    logic [DW-1:0] s_RDATA_i;
    logic [RW-1:0] s_RRESP_i;
    logic          s_RLAST_i;
    logic          s_RVALID_i;
    logic          s_RREADY_o;
    logic [IW-1:0] m_RID_o;
    logic [DW-1:0] m_RDATA_o;
    logic [RW-1:0] m_RRESP_o;
    logic          m_RLAST_o;
    logic          m_RVALID_o;
    logic          m_RREADY_i;

    int total = 0;
    int bad   = 0;

    // Model: queue of outstanding crossing flags, whether the head burst already
    // delivered its first half, and the beat currently presented upstream.
    bit            mq[$];
    bit            half_done;
    logic          exp_valid;
    logic          exp_last;
    logic [IW-1:0] exp_id;
    logic [DW-1:0] exp_data;
    logic [RW-1:0] exp_resp;

    always #5 clk = ~clk;

    splitting_4kb_rdata_merger #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .RESP_WIDTH (RW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .ACLK_i          (clk),
        .ARESET_i        (ARESET_i),
        .ar_push_i       (ar_push_i),
        .crossing_flag_i (crossing_flag_i),
        .ar_full_o       (ar_full_o),
        .s_RID_i         (s_RID_i),
        .s_RDATA_i       (s_RDATA_i),
        .s_RRESP_i       (s_RRESP_i),
        .s_RLAST_i       (s_RLAST_i),
        .s_RVALID_i      (s_RVALID_i),
        .s_RREADY_o      (s_RREADY_o),
        .m_RID_o         (m_RID_o),
        .m_RDATA_o       (m_RDATA_o),
        .m_RRESP_o       (m_RRESP_o),
        .m_RLAST_o       (m_RLAST_o),
        .m_RVALID_o      (m_RVALID_o),
        .m_RREADY_i      (m_RREADY_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        half_done = 1'b0;
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        exp_id    = '0;
        exp_data  = '0;
        exp_resp  = '0;
    endtask

    task automatic drive(input bit push, input bit flag, input bit sv, input bit last,
                         input logic [DW-1:0] data, input bit mready);
        ar_push_i       = push;
        crossing_flag_i = flag;
        s_RVALID_i      = sv;
        s_RLAST_i       = last;
        s_RDATA_i       = data;
        s_RID_i         = IW'($urandom);
        s_RRESP_i       = RW'($urandom);
        m_RREADY_i      = mready;
    endtask

    // One clock: compare DUT against model with current inputs, then advance the model.
    // Called just after a falling edge with inputs already driven.
    task automatic step();
        bit rdy;
        bit acc;
        bit push_ok;
        #1;
        rdy = (mq.size() > 0) && (!exp_valid || m_RREADY_i);
        check("s_rready", 64'(s_RREADY_o), 64'(rdy));
        check("ar_full",  64'(ar_full_o),  64'(mq.size() == DEPTH));
        check("m_rvalid", 64'(m_RVALID_o), 64'(exp_valid));
        check("m_rlast",  64'(m_RLAST_o),  64'(exp_last));
        check("m_rid",    64'(m_RID_o),    64'(exp_id));
        check("m_rdata",  64'(m_RDATA_o),  64'(exp_data));
        check("m_rresp",  64'(m_RRESP_o),  64'(exp_resp));
        @(posedge clk);
        if (ARESET_i) begin
            model_clear();
        end else begin
            acc     = s_RVALID_i && rdy;
            push_ok = ar_push_i && (mq.size() < DEPTH);
            if (acc) begin
                exp_valid = 1'b1;
                exp_id    = s_RID_i;
                exp_data  = s_RDATA_i;
                exp_resp  = s_RRESP_i;
                exp_last  = 1'b0;
                if (s_RLAST_i) begin
                    if (mq[0] && !half_done) begin
                        half_done = 1'b1;
                    end else begin
                        exp_last  = 1'b1;
                        half_done = 1'b0;
                        void'(mq.pop_front());
                    end
                end
            end else if (exp_valid && m_RREADY_i) begin
                exp_valid = 1'b0;
            end
            if (push_ok) mq.push_back(crossing_flag_i);
        end
        @(negedge clk);
    endtask

    initial begin
        int beats;
        int lasts;

        ARESET_i = 1'b1;
        drive(0, 0, 0, 0, '0, 0);
        @(negedge clk);
        @(negedge clk);
        model_clear();
        ARESET_i = 1'b0;

        // Reset state
        check("rst_rvalid", 64'(m_RVALID_o), 64'd0);
        check("rst_rready", 64'(s_RREADY_o), 64'd0);
        check("rst_full",   64'(ar_full_o),  64'd0);
        check("rst_rdata",  64'(m_RDATA_o),  64'd0);

        // Non-crossing burst of 8
        drive(1, 0, 0, 0, '0, 1); step();
        beats = 0; lasts = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, (i == 7), DW'(32'hA0 + i), 1); step();
            if (m_RVALID_o) beats++;
            if (m_RVALID_o && m_RLAST_o) lasts++;
        end
        check("nc_beats",    64'(beats),      64'd8);
        check("nc_lasts",    64'(lasts),      64'd1);
        check("nc_lastdata", 64'(m_RDATA_o),  64'hA7);
        check("nc_rlast",    64'(m_RLAST_o),  64'd1);
        check("nc_empty",    64'(s_RREADY_o), 64'd0);

        // Crossing burst: sub-bursts of 2 and 6
        drive(1, 1, 0, 0, '0, 1); step();
        lasts = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, (i == 1 || i == 7), DW'(32'hB0 + i), 1); step();
            check("cx_data", 64'(m_RDATA_o), 64'(32'hB0 + i));
            if (m_RVALID_o && m_RLAST_o) lasts++;
            if (i == 1) begin
                check("cx_mid_rlast", 64'(m_RLAST_o),  64'd0);
                check("cx_mid_rdy",   64'(s_RREADY_o), 64'd1);
            end
        end
        check("cx_lasts",  64'(lasts),      64'd1);
        check("cx_rlast",  64'(m_RLAST_o),  64'd1);
        check("cx_empty",  64'(s_RREADY_o), 64'd0);

        // Backpressure mid-burst
        drive(1, 0, 0, 0, '0, 1); step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, (i == 5), DW'(32'hC0 + i), 1); step();
            check("bp_data", 64'(m_RDATA_o), 64'(32'hC0 + i));
            if (i == 3) begin
                for (int k = 0; k < 3; k++) begin
                    drive(0, 0, 1, 0, DW'(32'hEE), 0); step();
                    check("bp_hold_data", 64'(m_RDATA_o),  64'hC3);
                    check("bp_hold_vld",  64'(m_RVALID_o), 64'd1);
                    check("bp_rready",    64'(s_RREADY_o), 64'd0);
                end
            end
        end

        // Full queue
        drive(0, 0, 0, 0, '0, 1); step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, '0, 1); step();
        end
        check("full_set", 64'(ar_full_o), 64'd1);
        drive(1, 1, 0, 0, '0, 1); step();
        check("full_hold", 64'(ar_full_o), 64'd1);
        drive(0, 0, 1, 1, DW'(32'hD0), 1); step();
        check("full_drop", 64'(ar_full_o), 64'd0);
        check("full_rlast0", 64'(m_RLAST_o), 64'd1);
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 1, 1, DW'(32'hD0 + i), 1); step();
            check("full_rlast", 64'(m_RLAST_o), 64'd1);
        end
        drive(0, 0, 0, 0, '0, 1); step();
        check("full_5th_dropped", 64'(s_RREADY_o), 64'd0);

        // Valid data with no queued flag
        drive(0, 0, 1, 0, DW'(32'h55), 1); step();
        drive(0, 0, 1, 1, DW'(32'h56), 1); step();
        check("empty_rready", 64'(s_RREADY_o), 64'd0);
        check("empty_rvalid", 64'(m_RVALID_o), 64'd0);

        // Reset while in the second half of a split burst
        drive(1, 1, 0, 0, '0, 1); step();
        drive(0, 0, 1, 0, DW'(32'h70), 1); step();
        drive(0, 0, 1, 1, DW'(32'h71), 1); step();
        check("rs2_mid_rlast", 64'(m_RLAST_o), 64'd0);
        ARESET_i = 1'b1;
        drive(0, 0, 0, 0, '0, 0); step();
        ARESET_i = 1'b0;
        check("rs2_rvalid", 64'(m_RVALID_o), 64'd0);
        check("rs2_rlast",  64'(m_RLAST_o),  64'd0);
        check("rs2_rid",    64'(m_RID_o),    64'd0);
        check("rs2_rdata",  64'(m_RDATA_o),  64'd0);
        check("rs2_rresp",  64'(m_RRESP_o),  64'd0);
        check("rs2_rready", 64'(s_RREADY_o), 64'd0);
        check("rs2_full",   64'(ar_full_o),  64'd0);
        drive(1, 1, 0, 0, '0, 1); step();
        drive(0, 0, 1, 1, DW'(32'h80), 1); step();
        check("rs2_first_half", 64'(m_RLAST_o), 64'd0);
        drive(0, 0, 1, 1, DW'(32'h81), 1); step();
        check("rs2_second_half", 64'(m_RLAST_o), 64'd1);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            ARESET_i = ($urandom_range(0, 399) == 0);
            drive(($urandom_range(0, 99) < 30), $urandom_range(0, 1),
                  ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 30),
                  DW'($urandom), ($urandom_range(0, 99) < 75));
            step();
        end
        ARESET_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/splitting_4kb_rdata_merger.md
# splitting_4kb_rdata_merger

Sits on the R channel behind the 4KB splitter. It re-joins the two downstream read sub-bursts produced for a boundary-crossing AR back into one burst toward the originating master. It keeps an in-order queue of crossing flags, one per issued AR. On each downstream RLAST it either suppresses the RLAST (end of the first half of a split) or forwards it and retires the queue entry. Output is a registered pipeline stage with 1-cycle latency and full throughput.

## Interface
- DATA_WIDTH, 32, RDATA width
- ID_WIDTH, 5, RID width
- RESP_WIDTH, 2, RRESP width
- FIFO_DEPTH, 4, outstanding-AR capacity of flag queue (power of 2, ≥2)

Ports:
- ACLK_i  in  1  clock; everything sampled on rising edge
- ARESET_i  in  1  reset, synchronous, active-high
- ar_push_i  in  1  original AR accepted downstream this cycle (first sub-burst handshake only)
- crossing_flag_i  in  1  splitter crossing flag for that AR
- ar_full_o  out  1  flag queue full; upstream must not push
- s_RID_i  in  ID_WIDTH  downstream RID
- s_RDATA_i  in  DATA_WIDTH  downstream RDATA
- s_RRESP_i  in  RESP_WIDTH  downstream RRESP
- s_RLAST_i  in  1  downstream RLAST (per sub-burst)
- s_RVALID_i  in  1  downstream RVALID
- s_RREADY_o  out  1  downstream RREADY
- m_RID_o  out  ID_WIDTH  merged RID
- m_RDATA_o  out  DATA_WIDTH  merged RDATA
- m_RRESP_o  out  RESP_WIDTH  per-beat RRESP, passed through unchanged
- m_RLAST_o  out  1  merged RLAST
- m_RVALID_o  out  1  merged RVALID
- m_RREADY_i  in  1  upstream RREADY

## Operation
- Flag queue: 1-bit FIFO. Push happens when ar_push_i & ~ar_full_o. Pop happens on an accepted downstream beat with s_RLAST_i whose merge is complete. ar_full_o = (count == FIFO_DEPTH), based on count only. A push at full is dropped even if a pop occurs in the same cycle. A simultaneous push and pop below full leaves count unchanged.
- s_RREADY_o = queue_not_empty & (~m_RVALID_o | m_RREADY_i). Combinational; no dependency on s_RVALID_i.
- Beat accept: s_RVALID_i & s_RREADY_o. It loads m_RID/RDATA/RRESP and sets m_RVALID_o = 1.
- FSM with two states, PART_FIRST and PART_SECOND. Reset state is PART_FIRST.
  - PART_FIRST, accepted beat with s_RLAST_i and head flag = 1: set m_RLAST_o = 0; go to PART_SECOND; no pop.
  - PART_FIRST, accepted beat with s_RLAST_i and head flag = 0: set m_RLAST_o = 1; pop.
  - PART_SECOND, accepted beat with s_RLAST_i: set m_RLAST_o = 1; pop; go to PART_FIRST.
  - Any accepted beat without s_RLAST_i: m_RLAST_o = 0, state held.
- Output handshake: when m_RVALID_o & m_RREADY_i and no new beat is accepted, m_RVALID_o clears. While m_RVALID_o & ~m_RREADY_i, all m_* outputs stay stable.
- Responses are in order; the second half carries the same RID as the first. No ID check is made.

## Timing
- Reset (sampled ARESET_i = 1) clears:
  - outputs: m_RVALID_o = 0, m_RLAST_o = 0, m_RID_o = 0, m_RDATA_o = 0, m_RRESP_o = 0
  - queue count = 0, so ar_full_o = 0 and s_RREADY_o = 0
  - FSM = PART_FIRST
- Reset mid-burst discards queue and state.
- Latency: beat accepted at edge N appears on m_* after edge N.
- Throughput: 1 beat/cycle while m_RREADY_i = 1.
- A push at edge N makes the entry poppable from edge N+1.
- A pop frees a slot in the same edge; ar_full_o falls after that edge.

## Structure
- Shared package splitting_pkg holds:
  - merge state enum (PART_FIRST, PART_SECOND)
  - default widths
  - RRESP constants (OKAY/EXOKAY/SLVERR/DECERR)
- One sub-module, split_flag_fifo: parameterized sync FIFO (width 1, depth FIFO_DEPTH) exposing head, count, full and empty.
- Merge FSM and output register live in the top module.

## Test plan
- Non-crossing: push flag 0, 8 beats, s_RLAST on beat 8 → 8 m_ beats, m_RLAST only on beat 8, queue empty after.
- Crossing (ADDR 8190, SIZE 0, LEN 7 → sub-bursts of 2 and 6): push flag 1, s_RLAST on beats 2 and 8 → m_RLAST only on beat 8. FSM is PART_SECOND after beat 2. Data order preserved.
- Backpressure: m_RREADY_i low for 3 cycles mid-burst → m_* stable, s_RREADY_o = 0. Resumes at 1 beat/cycle.
- Full: 4 pushes → ar_full_o = 1. A 5th push is ignored. Completing one burst drops ar_full_o.
- Empty queue: s_RVALID_i = 1 with no pushed flags → s_RREADY_o = 0, m_RVALID_o = 0.
- Reset in PART_SECOND → next cycle all outputs 0, queue empty, FSM PART_FIRST.
